// File: rtl/pito_pkg.sv
// Shared pito constants and types: APB widths, APB arbiter state encoding and
// the read-data pattern returned when an APB access is abandoned.
package pito_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS,
    ARB_RESP
  } apb_arb_state_e;

  localparam logic [31:0] APB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/pito_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of valid at or
// after ptr, wrapping from NUM_REQ-1 back to 0. Reusable for any hart-shared resource.
module pito_rr_picker #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_valid,
  output logic [IDX_W-1:0]   pick
);

  logic             lo_found;
  logic             hi_found;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;

  // Descending scan so the final assignment is the lowest matching index;
  // "hi" covers indices at or after ptr, "lo" is the wrap-around fallback.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (valid[j]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(j);
        if (j >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end
      end
    end
    any_valid = lo_found;
    pick      = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/pito_apb_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ harts.
// Optional ACCESS-phase timeout is enabled with `define PITO_APB_TIMEOUT_EN.
module pito_apb_arbiter
  import pito_pkg::*;
#(
  parameter int NUM_REQ        = 8,
  parameter int ADDR_WIDTH     = pito_pkg::APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = pito_pkg::APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  apb_arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    any_valid;
  logic [IDX_W-1:0]        pick;
  logic                    abort;

  pito_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .any_valid (any_valid),
    .pick      (pick)
  );

`ifdef PITO_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ARB_SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == ARB_ACCESS && !pready) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign abort = (state_q == ARB_ACCESS) && !pready &&
                 (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (any_valid) state_d = ARB_SETUP;
      ARB_SETUP:  state_d = ARB_ACCESS;
      ARB_ACCESS: if (pready || abort) state_d = ARB_RESP;
      ARB_RESP:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          req_ready = NUM_REQ'(1) << pick;
          grant_d   = pick;
          paddr_d   = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d  = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          pwrite_d  = req_write[pick];
          psel_d    = 1'b1;
        end
      end
      ARB_SETUP: penable_d = 1'b1;
      ARB_ACCESS: begin
        // pslverr only counts when the slave completes the transfer
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end else if (abort) begin
          rsp_rdata_d = DATA_WIDTH'(APB_TIMEOUT_DATA);
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end
      end
      ARB_RESP: begin
        rsp_valid_d = NUM_REQ'(1) << grant_q;
        rr_ptr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: doc/pito_apb_arbiter.md
Name: pito_apb_arbiter

Overview:
Shares the single SoC APB master port between the 8 pito harts (requesters) that issue MVU/peripheral configuration accesses. Each hart posts one read or write request. The block grants requesters round-robin, sequences the APB SETUP/ACCESS phases, and returns read data and error status to the granted requester. It sits between the core's per-hart CSR/MMIO request path and the top-level APB master interface of pito_soc.

Parameters:
NUM_REQ, 8, number of requesters (harts); any value >= 2, not restricted to powers of two
ADDR_WIDTH, pito_pkg::APB_ADDR_WIDTH, APB address width
DATA_WIDTH, pito_pkg::APB_DATA_WIDTH, APB data width
TIMEOUT_CYCLES, 256, ACCESS-phase limit; used only with PITO_APB_TIMEOUT_EN

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held with its payload stable until req_ready
req_ready  out  NUM_REQ  one-hot accept pulse (combinational)
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  shared read data; valid only when a rsp_valid bit is high
rsp_err  out  1  shared slave error flag; valid with rsp_valid
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB write
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset: state IDLE, rr_ptr=0, grant=0. psel, penable, pwrite, rsp_valid and rsp_err are 0. paddr, pwdata and rsp_rdata are 0.
- All APB outputs and all rsp_* outputs are registered. req_ready is combinational and is high only in IDLE.
- IDLE state:
  - If any req_valid is high, pick the first valid index at or after rr_ptr, wrapping from NUM_REQ-1 to 0.
  - Assert req_ready[pick] in that cycle.
  - Latch pick, write, addr and wdata into paddr, pwrite and pwdata.
  - Assert psel. Go to SETUP.
- SETUP state: psel=1, penable=0. Exactly one cycle, then go to ACCESS.
- ACCESS state: psel=1, penable=1.
  - On pready=1: latch prdata into rsp_rdata (0 for writes) and latch pslverr into rsp_err.
  - Drop psel and penable. Go to RESP.
- RESP state:
  - rsp_valid[grant]=1 for exactly one cycle.
  - rr_ptr = (grant+1) mod NUM_REQ.
  - Go to IDLE. The next grant occurs no earlier than the following cycle.
- Minimum latency: 4 cycles from acceptance to rsp_valid. Throughput: at most one transaction per 4 cycles.
- Simultaneous requests are served strictly round-robin. A requester asserting valid while another transaction is in flight waits; it is never dropped.
- Only one transaction is outstanding at a time. psel never toggles within a transaction.
- Reset mid-transaction: at the next edge, psel=0 and state is IDLE. The in-flight response is discarded and no rsp_valid is produced.
- pslverr is ignored when pready=0.

Optional Feature:
Macro: PITO_APB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each cycle while pready=0. When it reaches TIMEOUT_CYCLES-1 with pready still 0, the transaction is aborted: psel and penable drop, rsp_err=1, rsp_rdata=32'hDEAD_BEEF (truncated/zero-extended to DATA_WIDTH), and the state goes to RESP.
- Not defined: ACCESS waits indefinitely; no counter logic exists.

Decomposition:
- pito_pkg gains:
  - typedef enum logic [1:0] apb_arb_state_e {ARB_IDLE, ARB_SETUP, ARB_ACCESS, ARB_RESP}
  - localparam APB_TIMEOUT_DATA = 32'hDEAD_BEEF
- Width constants come from the existing APB_ADDR_WIDTH and APB_DATA_WIDTH.
- One sub-module, pito_rr_picker:
  - Combinational; inputs valid vector and ptr, outputs any_valid and pick index.
  - Parameterised by NUM_REQ; reusable by other hart-shared resources.

Test Plan:
1. Single write: hart 3 writes addr 0x100, data 0xA5A5_0001; pready=1 immediately -> psel rises at T+1, penable at T+2, rsp_valid[3] at T+4, rsp_err=0, rr_ptr=4.
2. All 8 harts request reads at once; slave returns prdata = 0x10+index -> grants in order 0..7, each rsp_valid one-hot with matching rdata, 32 cycles total.
3. Wrap: rr_ptr=6, harts 1 and 7 valid -> hart 7 served first, then hart 1.
4. Wait states and error: pready low for 5 cycles, then high with pslverr=1 -> penable held 6 cycles, rsp_err=1 with rsp_valid.
5. Reset in ACCESS: assert rst for one cycle -> psel=0 next edge, no rsp_valid, next request granted from index 0.
6. With PITO_APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready stuck at 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0xDEAD_BEEF.
